// File: rtl/mod_n_counter_pkg.sv
// Shared types and the wrap-step helper for the modulo-N up/down counter.
// The helper works on 32-bit values so it serves any WIDTH/N pairing.
package mod_n_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // One modulo-n step in the given direction.
  // The wrap values are explicit, so the step never relies on natural overflow.
  function automatic logic [31:0] wrap_step(
    input logic [31:0] q,
    input dir_e        dir,
    input int unsigned n,
    input int unsigned width
  );
    logic [31:0] last_v;
    logic [31:0] mask_v;
    logic [31:0] res_v;
    last_v = 32'(n) - 32'd1;
    mask_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (dir == DIR_UP) begin
      res_v = (q == last_v) ? 32'd0 : (q + 32'd1);
    end else begin
      res_v = (q == 32'd0) ? last_v : (q - 32'd1);
    end
    return res_v & mask_v;
  endfunction

endpackage

// File: rtl/mod_n_next_state.sv
// Combinational next-count logic for mod_n_counter.
// Out-of-range counts recover to 0 on the next enabled edge.
module mod_n_next_state
  import mod_n_counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N     = 6
) (
  input  logic [WIDTH-1:0] q,
  input  logic             i_en,
  input  logic             i_up_down,
  output logic [WIDTH-1:0] next_q
);

  localparam logic [WIDTH-1:0] LAST_Q = WIDTH'(N - 1);

  logic [WIDTH-1:0] step_s;

  // Wrapped step value in the requested direction.
  always_comb begin
    step_s = WIDTH'(wrap_step(32'(q), dir_e'(i_up_down), N, WIDTH));
  end

  // Hold, recover from an illegal count, or take the wrapped step.
  always_comb begin
    next_q = q;
    if (!i_en) begin
      next_q = q;
    end else if (q > LAST_Q) begin
      next_q = {WIDTH{1'b0}};
    end else begin
      next_q = step_s;
    end
  end

endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter; the state register is the count and drives o_Q.
// Cyclic index / divider leaf block.
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N     = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up_down,
  output logic [WIDTH-1:0] o_Q
);

  generate
    if ((N < 2) || (N > (2 ** WIDTH))) begin : g_bad_params
      $error("mod_n_counter: N=%0d outside 2..2**WIDTH (WIDTH=%0d)", N, WIDTH);
    end
  endgenerate

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;

  mod_n_next_state #(
    .WIDTH(WIDTH),
    .N    (N)
  ) u_next (
    .q        (q_r),
    .i_en     (i_en),
    .i_up_down(i_up_down),
    .next_q   (q_next_s)
  );

  // Count register; active-low reset clears it without waiting for a clock.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      q_r <= {WIDTH{1'b0}};
    end else begin
      q_r <= q_next_s;
    end
  end

  assign o_Q = q_r;

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter: directed scenarios plus random stimulus,
// with N=6 and N=8 instances sharing inputs and checked against an arithmetic model.
module tb_mod_n_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       ud;
  logic [2:0] q6;
  logic [2:0] q8;
  int         m6;
  int         m8;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  mod_n_counter #(.WIDTH(3), .N(6)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up_down(ud), .o_Q(q6)
  );

  mod_n_counter #(.WIDTH(3), .N(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up_down(ud), .o_Q(q8)
  );

  // Reference rule: hold, recover illegal counts to 0, otherwise modular step.
  function automatic int model_next(int m, int n);
    if (!en) return m;
    if (m >= n) return 0;
    return ud ? (m + 1) % n : (m + n - 1) % n;
  endfunction

  // Advance the model for the coming edge, then sample 1 ns after it.
  task automatic tick();
    if (!rst) begin
      m6 = 0;
      m8 = 0;
    end else begin
      m6 = model_next(m6, 6);
      m8 = model_next(m8, 8);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; ud = 1'b1; m6 = 0; m8 = 0;
    #1;
    repeat (2) tick();
    n_cmp++;
    if (q6 !== 3'd0 || q8 !== 3'd0) begin
      n_bad++; $display("FAIL reset_initial: q6=%0d q8=%0d expected 0 0", q6, q8);
    end
    rst = 1'b1; en = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (q6 !== 3'd4) begin
      n_bad++; $display("FAIL reset_precount: q6=%0d expected 4", q6);
    end
    #2 rst = 1'b0; m6 = 0; m8 = 0;
    #1;
    n_cmp++;
    if (q6 !== 3'd0 || q8 !== 3'd0) begin
      n_bad++; $display("FAIL reset_async: q6=%0d q8=%0d expected 0 0", q6, q8);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (q6 !== 3'd0 || q8 !== 3'd0) begin
        n_bad++; $display("FAIL reset_held%0d: q6=%0d q8=%0d expected 0 0", i, q6, q8);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_up_count();
    int exp6 [7] = '{1, 2, 3, 4, 5, 0, 1};
    en = 1'b1; ud = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if (q6 !== 3'(exp6[i]) || q8 !== 3'(m8)) begin
        n_bad++;
        $display("FAIL up_count%0d: q6=%0d q8=%0d expected %0d %0d", i, q6, q8, exp6[i], m8);
      end
    end
  endtask

  task automatic test_down_wrap();
    int exp6 [4] = '{1, 0, 5, 4};
    en = 1'b1; ud = 1'b1;
    tick();
    n_cmp++;
    if (q6 !== 3'd2) begin
      n_bad++; $display("FAIL down_start: q6=%0d expected 2", q6);
    end
    ud = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (q6 !== 3'(exp6[i]) || q8 !== 3'(m8)) begin
        n_bad++;
        $display("FAIL down_wrap%0d: q6=%0d q8=%0d expected %0d %0d", i, q6, q8, exp6[i], m8);
      end
    end
    ud = 1'b1;
    tick();
    n_cmp++;
    if (q6 !== 3'd5) begin
      n_bad++; $display("FAIL reverse_up: q6=%0d expected 5", q6);
    end
  endtask

  task automatic test_hold();
    en = 1'b1; ud = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (q6 !== 3'd3) begin
      n_bad++; $display("FAIL hold_start: q6=%0d expected 3", q6);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ud = ~ud;
      tick();
      n_cmp++;
      if (q6 !== 3'd3 || q8 !== 3'(m8)) begin
        n_bad++; $display("FAIL hold%0d: q6=%0d q8=%0d expected 3 %0d", i, q6, q8, m8);
      end
    end
    en = 1'b1; ud = 1'b1;
    tick();
    n_cmp++;
    if (q6 !== 3'd4) begin
      n_bad++; $display("FAIL hold_resume: q6=%0d expected 4", q6);
    end
  endtask

  task automatic test_reset_release();
    en = 1'b1; ud = 1'b1;
    tick();
    n_cmp++;
    if (q6 !== 3'd5) begin
      n_bad++; $display("FAIL rr_start: q6=%0d expected 5", q6);
    end
    #3 rst = 1'b0; m6 = 0; m8 = 0;
    #1;
    n_cmp++;
    if (q6 !== 3'd0 || q8 !== 3'd0) begin
      n_bad++; $display("FAIL rr_during: q6=%0d q8=%0d expected 0 0", q6, q8);
    end
    #9 rst = 1'b1;
    n_cmp++;
    if (q6 !== 3'd0) begin
      n_bad++; $display("FAIL rr_over_edge: q6=%0d expected 0", q6);
    end
    tick();
    n_cmp++;
    if (q6 !== 3'd1 || q8 !== 3'd1) begin
      n_bad++; $display("FAIL rr_first_edge: q6=%0d q8=%0d expected 1 1", q6, q8);
    end
  endtask

  task automatic test_full_range();
    int budget = 0;
    en = 1'b1; ud = 1'b1;
    while (m8 != 6 && budget < 8) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (q8 !== 3'd6) begin
      n_bad++; $display("FAIL full_start: q8=%0d expected 6", q8);
    end
    tick();
    n_cmp++;
    if (q8 !== 3'd7) begin
      n_bad++; $display("FAIL full_up7: q8=%0d expected 7", q8);
    end
    tick();
    n_cmp++;
    if (q8 !== 3'd0) begin
      n_bad++; $display("FAIL full_wrap0: q8=%0d expected 0", q8);
    end
    ud = 1'b0;
    tick();
    n_cmp++;
    if (q8 !== 3'd7 || q6 !== 3'(m6)) begin
      n_bad++; $display("FAIL full_down7: q8=%0d q6=%0d expected 7 %0d", q8, q6, m6);
    end
  endtask

  task automatic test_illegal_recovery();
    force dut6.q_r = 3'd7;
    m6 = 7;
    #1 release dut6.q_r;
    #1;
    n_cmp++;
    if (q6 !== 3'd7) begin
      n_bad++; $display("FAIL illegal_forced: q6=%0d expected 7", q6);
    end
    en = 1'b0; ud = 1'b0;
    tick();
    n_cmp++;
    if (q6 !== 3'd7) begin
      n_bad++; $display("FAIL illegal_hold: q6=%0d expected 7", q6);
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (q6 !== 3'd0) begin
      n_bad++; $display("FAIL illegal_recover: q6=%0d expected 0", q6);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      ud = 1'($urandom);
      rst = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      tick();
      n_cmp++;
      if (q6 !== 3'(m6) || q8 !== 3'(m8)) begin
        n_bad++;
        $display("FAIL random%0d: q6=%0d q8=%0d expected %0d %0d", i, q6, q8, m6, m8);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_hold();
    test_reset_release();
    test_full_range();
    test_illegal_recovery();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_n_counter.md
# mod_n_counter

Parameterised modulo-N up/down counter, implemented as a small Moore state machine whose state is the count value. It counts through 0..N-1 with wrap-around in either direction, holds when disabled, and drives the count directly as its output. It is a leaf block used wherever a cyclic index or divider state is needed.

## Interface
- WIDTH, default 3: width of the count/state register and of o_Q.
- N, default 6: modulus; legal range 2 <= N <= 2**WIDTH. Elaboration fails (assertion) outside this range.

- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset, asynchronous, active-low; forces count to 0 immediately.
- i_en  input  1  count enable; 1 = step on this edge, 0 = hold.
- i_up_down  input  1  direction; 1 = increment, 0 = decrement.
- o_Q  output  WIDTH  current count, registered, always in 0..N-1.

## Operation
- State register q[WIDTH-1:0]; o_Q = q (no combinational path from inputs to o_Q).
- Reset asserted (i_rst = 0): q = 0 asynchronously, held while asserted regardless of clock or other inputs.
- Next state, evaluated each rising edge with reset deasserted:
  - i_en = 0: q holds.
  - i_en = 1, i_up_down = 1: q = (q == N-1) ? 0 : q+1.
  - i_en = 1, i_up_down = 0: q = (q == 0) ? N-1 : q-1.
- Comparisons use WIDTH-bit arithmetic; N-1 is cast to WIDTH bits. No carry beyond WIDTH is ever generated: increment at N-1 and decrement at 0 use the explicit wrap values, never natural overflow.
- Illegal state recovery: if q >= N (only possible when N < 2**WIDTH, e.g. after an upset), the next enabled edge loads 0 regardless of direction. A disabled edge holds.
- Direction may change on any cycle; the new direction takes effect on the same edge it is sampled. No extra state is added on direction reversal.
- No terminal-count or carry output; consumers decode o_Q.

## Timing
- Latency: one cycle. Inputs sampled at rising edge k; o_Q shows the new value after edge k.
- Reset assertion: o_Q = 0 without waiting for a clock edge.
- Reset deassertion: synchronised externally. The first rising edge with i_rst = 1 is a normal edge; with i_en = 1 and i_up_down = 1 it moves 0 -> 1.
- Reset mid-count overrides i_en and i_up_down in all states.
- i_en and i_up_down must meet setup/hold to i_clk; there is no handshake.

## Structure
- Package mod_n_counter_pkg:
  - direction enum: DIR_DOWN = 1'b0, DIR_UP = 1'b1.
  - Helper function for wrap-increment/decrement, parameterised by N and WIDTH through arguments.
- Sub-module mod_n_next_state (purely combinational) takes q, i_en, i_up_down and produces the next q, including illegal-state recovery.
- Top-level mod_n_counter contains:
  - Parameter assertions.
  - The asynchronous-reset state register.
  - The output assignment.

## Test plan
- Reset: with WIDTH=3, N=6, drive i_rst=0 mid-cycle from count 4 -> o_Q = 0 before the next edge; it stays 0 while reset is held.
- Up count: reset, then i_en=1, i_up_down=1 for 7 edges -> o_Q = 1,2,3,4,5,0,1.
- Down count and wrap: from o_Q=2, i_up_down=0 for 4 edges -> 1,0,5,4. Reversing to up for one edge -> 5.
- Hold: at o_Q=3, i_en=0 for 3 edges with i_up_down toggling -> o_Q stays 3. Re-enable up -> 4.
- Reset mid-operation and release: count up to 5, pulse i_rst low for 10 ns with i_en=1. After release, the first edge -> 1.
- Full range: WIDTH=3, N=8, up from 6 -> 7,0. Down from 0 -> 7. Also force q=7 with N=6 -> next enabled edge -> 0, disabled edge -> holds 7.
